// File: rtl/alu_request_arbiter.sv
// rtl/alu_request_arbiter.sv - round-robin arbiter sharing one multi-cycle ALU among requesters
//
// Purpose:
//   Grants one of NUM_REQ requesters access to a single ALU, holds the
//   granted opcode/operands on the ALU for ALU_LAT cycles, captures the
//   result and returns it to the owner as a one-cycle response pulse.
//   Illegal opcodes and divide-by-zero are answered with an error response
//   without ever driving the ALU.
//
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   req_valid       per-requester request pending
//   req_ready       per-requester grant, only ever asserted in IDLE
//   req_opcode      4 bits per requester, requester i at [4i+3:4i]
//   req_op_a/b      DATA_W bits per requester, requester i at [DATA_W*i +: DATA_W]
//   rsp_valid       one-hot, one-cycle response pulse to the owner
//   rsp_result      result, meaningful while rsp_valid is non-zero
//   rsp_error       response was rejected (illegal opcode or divide by zero)
//   alu_opcode      to ALU, 4'b0000 when not executing
//   alu_operand_a/b to ALU, 0 when not executing
//   alu_result      from ALU
//   busy            an operation is in flight (state != IDLE)

module alu_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int RES_W   = 32,
    parameter int ALU_LAT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [4*NUM_REQ-1:0]      req_opcode,
    input  logic [DATA_W*NUM_REQ-1:0] req_op_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_op_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [RES_W-1:0]          rsp_result,
    output logic                      rsp_error,
    output logic [3:0]                alu_opcode,
    output logic [DATA_W-1:0]         alu_operand_a,
    output logic [DATA_W-1:0]         alu_operand_b,
    input  logic [RES_W-1:0]          alu_result,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_MAX = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Round-robin pointer holds the last winner; search starts one above it.
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  owner;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              err_q;
    logic [RES_W-1:0]  res_q;
    logic [CNT_W-1:0]  cnt;

    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [3:0]        sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic              sel_reject;
    logic              handshake;
    logic              exec_last;

    // Winner search: first valid requester after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    // Only the winner's payload is looked at; non-winners are never sampled.
    assign sel_op = req_opcode[4*win_idx +: 4];
    assign sel_a  = req_op_a[DATA_W*win_idx +: DATA_W];
    assign sel_b  = req_op_b[DATA_W*win_idx +: DATA_W];

    assign sel_reject = (sel_op == OP_NOP) || (sel_op > OP_MAX) ||
                        ((sel_op == OP_DIV) && (sel_b == '0));

    // The winner's valid is set by construction, so a grant is a handshake.
    // Reset gating keeps ready low while reset is held.
    assign handshake = (state == IDLE) && win_found && !reset;

    assign exec_last = (cnt == CNT_W'(ALU_LAT - 1));

    assign busy = (state != IDLE);

    always_comb begin
        state_next    = state;
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_error     = 1'b0;
        rsp_result    = '0;
        alu_opcode    = OP_NOP;
        alu_operand_a = '0;
        alu_operand_b = '0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    req_ready[win_idx] = 1'b1;
                    state_next         = sel_reject ? RESP : EXEC;
                end
            end
            EXEC: begin
                alu_opcode    = op_q;
                alu_operand_a = a_q;
                alu_operand_b = b_q;
                if (exec_last) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                rsp_error        = err_q;
                rsp_result       = res_q;
                state_next       = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= PTR_W'(NUM_REQ - 1);
            owner  <= '0;
            op_q   <= OP_NOP;
            a_q    <= '0;
            b_q    <= '0;
            err_q  <= 1'b0;
            res_q  <= '0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        rr_ptr <= win_idx;
                        owner  <= win_idx;
                        op_q   <= sel_op;
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        err_q  <= sel_reject;
                        // Rejected ops answer with a zero result.
                        res_q  <= '0;
                        cnt    <= '0;
                    end
                end
                EXEC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (exec_last) begin
                        res_q <= alu_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// tb/tb_alu_request_arbiter.sv - self-checking bench for alu_request_arbiter
`timescale 1ns/1ps
module tb_alu_request_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int RES_W   = 32;
    localparam int ALU_LAT = 2;

    typedef struct { logic [3:0] op; logic [15:0] a; logic [15:0] b; } req_t;
    typedef struct { int cyc; int who; logic [31:0] res; logic err; } exp_t;
    typedef struct {
        int who; logic [3:0] op; logic [15:0] a; logic [15:0] b;
        logic [31:0] res; logic err; int lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NUM_REQ-1:0] vld = '0;
    logic [3:0]  op  [NUM_REQ];
    logic [15:0] a_v [NUM_REQ];
    logic [15:0] b_v [NUM_REQ];

    logic [NUM_REQ-1:0]        req_valid, req_ready, rsp_valid;
    logic [4*NUM_REQ-1:0]      req_opcode;
    logic [DATA_W*NUM_REQ-1:0] req_op_a, req_op_b;
    logic [RES_W-1:0]          rsp_result, alu_result;
    logic                      rsp_error, busy;
    logic [3:0]                alu_opcode;
    logic [DATA_W-1:0]         alu_operand_a, alu_operand_b;
    logic [RES_W-1:0]          alu_res_q = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    req_t q [NUM_REQ][$];
    int hs_cyc [NUM_REQ];
    logic [NUM_REQ-1:0] hs_last = '0;
    int grant_who[$];
    int grant_cyc[$];
    logic [NUM_REQ-1:0] rsp_who_log[$];
    logic [31:0] rsp_res_log[$];

    // Reference model state: transaction timing, not DUT state.
    int last_w = NUM_REQ - 1;
    int free_at = 0;
    int busy_to = -1;
    int ex_from = 0;
    int ex_to = -1;
    logic [3:0]  ex_op = '0;
    logic [15:0] ex_a = '0;
    logic [15:0] ex_b = '0;
    exp_t exp_q[$];

    vec_t tv [10];

    alu_request_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_op_a(req_op_a), .req_op_b(req_op_b),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
        .alu_opcode(alu_opcode), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_result(alu_result), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign req_valid = vld;
    always_comb begin
        req_opcode = '0;
        req_op_a = '0;
        req_op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_opcode[4*i +: 4]           = op[i];
            req_op_a[DATA_W*i +: DATA_W]   = a_v[i];
            req_op_b[DATA_W*i +: DATA_W]   = b_v[i];
        end
    end

    function automatic logic [31:0] alu_f(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            4'd1:    return {16'd0, a} + {16'd0, b};
            4'd2:    return {16'd0, a} - {16'd0, b};
            4'd3:    return {16'd0, a} * {16'd0, b};
            4'd4:    return (b == 16'd0) ? 32'hDEAD_BEEF : {16'd0, a / b};
            4'd5:    return {16'd0, a & b};
            4'd6:    return {16'd0, a | b};
            4'd7:    return {16'd0, a ^ b};
            4'd8:    return {16'd0, a} << b[3:0];
            4'd9:    return {16'd0, a} >> b[3:0];
            4'd10:   return {16'd0, ~a};
            4'd11:   return {16'd0, b};
            default: return 32'h0BAD_0000;
        endcase
    endfunction

    // Registered ALU: output reflects inputs held for ALU_LAT cycles at the capture edge.
    always @(posedge clk) alu_res_q <= alu_f(alu_opcode, alu_operand_a, alu_operand_b);
    assign alu_result = alu_res_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        int w;
        int lat;
        logic bad;
        logic in_ex;
        logic [NUM_REQ-1:0] er;
        logic [NUM_REQ-1:0] erv;
        exp_t e;
        hs_last = req_ready & req_valid;
        if (reset) begin
            last_w = NUM_REQ - 1;
            free_at = 0;
            busy_to = -1;
            ex_to = -1;
            exp_q.delete();
        end else if (mon_en) begin
            erv = '0;
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                erv = NUM_REQ'(1) << e.who;
                check("rsp_result", 64'(rsp_result), 64'(e.res));
                check("rsp_error", 64'(rsp_error), 64'(e.err));
            end
            check("rsp_valid", 64'(rsp_valid), 64'(erv));
            if (rsp_valid != '0) begin
                rsp_who_log.push_back(rsp_valid);
                rsp_res_log.push_back(rsp_result);
            end
            in_ex = (cyc >= ex_from) && (cyc <= ex_to);
            check("alu_opcode", 64'(alu_opcode), in_ex ? 64'(ex_op) : 64'd0);
            check("alu_operand_a", 64'(alu_operand_a), in_ex ? 64'(ex_a) : 64'd0);
            check("alu_operand_b", 64'(alu_operand_b), in_ex ? 64'(ex_b) : 64'd0);
            check("busy", 64'(busy), 64'(cyc <= busy_to));
            er = '0;
            w = -1;
            if (cyc >= free_at) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (w < 0 && vld[(last_w + k) % NUM_REQ]) w = (last_w + k) % NUM_REQ;
                end
            end
            if (w >= 0) er[w] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(er));
            if (w >= 0) begin
                bad = (op[w] == 4'd0) || (op[w] > 4'd11) || (op[w] == 4'd4 && b_v[w] == 16'd0);
                lat = bad ? 1 : ALU_LAT + 1;
                exp_q.push_back('{cyc + lat, w, bad ? 32'd0 : alu_f(op[w], a_v[w], b_v[w]), bad});
                free_at = cyc + lat + 1;
                busy_to = cyc + lat;
                last_w = w;
                if (!bad) begin
                    ex_from = cyc + 1;
                    ex_to = cyc + ALU_LAT;
                    ex_op = op[w];
                    ex_a = a_v[w];
                    ex_b = b_v[w];
                end
                grant_who.push_back(w);
                grant_cyc.push_back(cyc);
            end
        end
    end

    task automatic present();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (q[i].size() != 0) begin
                vld[i] = 1'b1; op[i] = q[i][0].op; a_v[i] = q[i][0].a; b_v[i] = q[i][0].b;
            end else begin
                vld[i] = 1'b0; op[i] = 4'd0; a_v[i] = 16'd0; b_v[i] = 16'd0;
            end
        end
    endtask

    task automatic push(input int who, input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        q[who].push_back('{o, a, b});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs_last[i] && q[i].size() != 0) begin
                q[i].delete(0);
                hs_cyc[i] = cyc - 1;
            end
        end
        present();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NUM_REQ; i++) if (q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            tick();
            done = all_empty() && !busy && (vld == '0);
        end
        check({name, "_drain"}, 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) q[i].delete();
        present();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit got;
        logic [NUM_REQ-1:0] rv;
        logic [31:0] rres;
        logic rerr;
        int rcyc;
        int who;

        tv[0] = '{0, 4'd1,  16'd10,  16'd5,      32'd15,        1'b0, 3};
        tv[1] = '{1, 4'd15, 16'd3,   16'd4,      32'd0,         1'b1, 1};
        tv[2] = '{3, 4'd4,  16'd25,  16'd0,      32'd0,         1'b1, 1};
        tv[3] = '{3, 4'd4,  16'd25,  16'd5,      32'd5,         1'b0, 3};
        tv[4] = '{2, 4'd3,  16'd300, 16'd200,    32'd60000,     1'b0, 3};
        tv[5] = '{1, 4'd0,  16'd1,   16'd1,      32'd0,         1'b1, 1};
        tv[6] = '{0, 4'd12, 16'd7,   16'd7,      32'd0,         1'b1, 1};
        tv[7] = '{2, 4'd2,  16'd15,  16'd7,      32'd8,         1'b0, 3};
        tv[8] = '{1, 4'd2,  16'd5,   16'd7,      32'hFFFF_FFFE, 1'b0, 3};
        tv[9] = '{0, 4'd11, 16'd1,   16'h1234,   32'h0000_1234, 1'b0, 3};

        // Reset state, with every requester asserting valid.
        vld = '1;
        for (int i = 0; i < NUM_REQ; i++) begin op[i] = 4'd1; a_v[i] = 16'd1; b_v[i] = 16'd1; end
        #12;
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_result", 64'(rsp_result), 64'd0);
        check("reset_rsp_error", 64'(rsp_error), 64'd0);
        check("reset_alu_opcode", 64'(alu_opcode), 64'd0);
        check("reset_alu_a", 64'(alu_operand_a), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        present();
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // Simultaneous requests: grants 0,1,2,3 spaced ALU_LAT+2 apart, each SUB 15-7 = 8.
        do_reset();
        grant_who.delete(); grant_cyc.delete(); rsp_who_log.delete(); rsp_res_log.delete();
        for (int i = 0; i < NUM_REQ; i++) push(i, 4'd2, 16'd15, 16'd7);
        present();
        drain("simul");
        check("simul_grants", 64'(grant_who.size()), 64'd4);
        for (int k = 0; k < grant_who.size() && k < 4; k++) begin
            check("simul_order", 64'(grant_who[k]), 64'(k));
            if (k > 0) check("simul_spacing", 64'(grant_cyc[k] - grant_cyc[k-1]), 64'(ALU_LAT + 2));
        end
        check("simul_rsps", 64'(rsp_who_log.size()), 64'd4);
        for (int k = 0; k < rsp_who_log.size() && k < 4; k++) begin
            check("simul_rsp_bit", 64'(rsp_who_log[k]), 64'(4'b0001 << k));
            check("simul_rsp_res", 64'(rsp_res_log[k]), 64'd8);
        end

        // Fairness: req0 and req2 continuously valid for 8 ops.
        grant_who.delete(); grant_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            push(0, 4'd1, 16'(k), 16'd1);
            push(2, 4'd3, 16'(k), 16'd3);
        end
        present();
        drain("fair");
        check("fair_grants", 64'(grant_who.size()), 64'd8);
        for (int k = 0; k < grant_who.size() && k < 8; k++)
            check("fair_order", 64'(grant_who[k]), (k % 2 == 0) ? 64'd0 : 64'd2);

        // Single-request vector table: fixed results, error flags and latency.
        for (int i = 0; i < 10; i++) begin
            push(tv[i].who, tv[i].op, tv[i].a, tv[i].b);
            present();
            got = 1'b0; rv = '0; rres = '0; rerr = 1'b0; rcyc = 0;
            for (int k = 0; k < 20 && !got; k++) begin
                tick();
                if (rsp_valid != '0) begin
                    got = 1'b1; rv = rsp_valid; rres = rsp_result; rerr = rsp_error; rcyc = cyc;
                end
            end
            check("vec_got_rsp", 64'(got), 64'd1);
            check("vec_rsp_valid", 64'(rv), 64'(4'b0001 << tv[i].who));
            check("vec_rsp_result", 64'(rres), 64'(tv[i].res));
            check("vec_rsp_error", 64'(rerr), 64'(tv[i].err));
            check("vec_latency", 64'(rcyc - hs_cyc[tv[i].who]), 64'(tv[i].lat));
        end
        drain("vec");

        // Reset during EXEC of a req2 MUL: op dropped, outputs clear at once, pointer reinitialised.
        push(2, 4'd3, 16'd7, 16'd6);
        present();
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            got = busy;
        end
        check("rst_mid_reached_exec", 64'(got), 64'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_alu_opcode", 64'(alu_opcode), 64'd0);
        check("rst_mid_alu_a", 64'(alu_operand_a), 64'd0);
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        for (int i = 0; i < NUM_REQ; i++) q[i].delete();
        present();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_hold_rsp_valid", 64'(rsp_valid), 64'd0);
            check("rst_hold_busy", 64'(busy), 64'd0);
        end
        reset = 1'b0;
        grant_who.delete(); grant_cyc.delete();
        push(0, 4'd1, 16'd1, 16'd2);
        push(2, 4'd1, 16'd3, 16'd4);
        push(3, 4'd1, 16'd5, 16'd6);
        present();
        for (int k = 0; k < 10 && grant_who.size() == 0; k++) tick();
        check("rst_first_grant_seen", 64'(grant_who.size() != 0), 64'd1);
        who = (grant_who.size() != 0) ? grant_who[0] : -1;
        check("rst_first_grant", 64'(who), 64'd0);
        drain("rst");

        // Randomized traffic against the transaction model.
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 2) == 0)
                    push(i, 4'($urandom_range(0, 15)), 16'($urandom),
                         ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
            end
            present();
            tick();
        end
        drain("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
